input_debounce: RTL and testbench



---
 rtl/input_debounce.sv | 150 +++++++++++++++
 tb/tb_input_debounce.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
//   Two-channel switch conditioner. Each raw switch level is passed through a
//   two-flop synchroniser, then a four-state debounce FSM that only accepts a
//   new level after it has been stable for STABLE_COUNT+1 consecutive ticks.
//   Clean levels drive the downstream OR gate; one-clk edge pulses are also
//   provided for counting logic. All outputs are registered.
//
// Parameters
//   STABLE_COUNT  stable ticks required to accept a change (>= 2)
//   TICK_DIV      sampling prescaler, one tick every TICK_DIV clks (>= 1)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   a_raw, b_raw    raw asynchronous switch inputs
//   a, b            debounced levels
//   a_rise, b_rise  one-clk pulse when the debounced level goes 0->1
//   a_fall, b_fall  one-clk pulse when the debounced level goes 1->0
// ---------------------------------------------------------------------------
module input_debounce #(
    parameter int unsigned STABLE_COUNT = 10,
    parameter int unsigned TICK_DIV     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise,
    output logic a_fall,
    output logic b_fall
);

    localparam int unsigned CNT_W = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        LOW,
        CHK_HI,
        HIGH,
        CHK_LO
    } state_t;

    // Prescaler: with TICK_DIV == 1 the counter sits at 0 == DIV_LAST, so tick
    // is permanently asserted.
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    logic [1:0] raw_in;
    assign raw_in = {b_raw, a_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             s1;
        logic             s2;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             lvl_q;
        logic             rise_q;
        logic             fall_q;

        // Outputs are assigned together with the state transition so the level
        // and its edge pulse become visible on the same cycle as HIGH/LOW is
        // entered. Pulses default low every clk, so they stay one clk wide
        // even when ticks are sparse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                state  <= LOW;
                cnt    <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                s1     <= raw_in[ch];
                s2     <= s1;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (tick) begin
                    unique case (state)
                        LOW: begin
                            if (s2) begin
                                state <= CHK_HI;
                                cnt   <= '0;
                            end
                        end
                        CHK_HI: begin
                            if (!s2) begin
                                state <= LOW;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state  <= HIGH;
                                cnt    <= '0;
                                lvl_q  <= 1'b1;
                                rise_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        HIGH: begin
                            if (!s2) begin
                                state <= CHK_LO;
                                cnt   <= '0;
                            end
                        end
                        CHK_LO: begin
                            if (s2) begin
                                state <= HIGH;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state  <= LOW;
                                cnt    <= '0;
                                lvl_q  <= 1'b0;
                                fall_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign a      = g_ch[0].lvl_q;
    assign b      = g_ch[1].lvl_q;
    assign a_rise = g_ch[0].rise_q;
    assign b_rise = g_ch[1].rise_q;
    assign a_fall = g_ch[0].fall_q;
    assign b_fall = g_ch[1].fall_q;

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
//   Drives two instances (defaults, and STABLE_COUNT=2/TICK_DIV=4) from the
//   same raw inputs. A reference model tracks, per channel, the accepted level
//   and the length of the current run of ticks whose synchronised sample
//   disagrees with it; a run of STABLE_COUNT+1 flips the level and pulses.
// ---------------------------------------------------------------------------
module tb_input_debounce;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;

    logic a0, b0, ar0, br0, af0, bf0;
    logic a1, b1, ar1, br1, af1, bf1;

    always #5 clk = ~clk;

    input_debounce dut0 (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
        .a(a0), .b(b0), .a_rise(ar0), .b_rise(br0), .a_fall(af0), .b_fall(bf0)
    );

    input_debounce #(.STABLE_COUNT(2), .TICK_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
        .a(a1), .b(b1), .a_rise(ar1), .b_rise(br1), .a_fall(af1), .b_fall(bf1)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int sc_v [2] = '{10, 2};
    int td_v [2] = '{1, 4};
    int m_cyc [2];
    int m_run [2][2];
    bit m_s1  [2][2];
    bit m_s2  [2][2];
    bit m_d   [2][2];
    bit m_rise[2][2];
    bit m_fall[2][2];

    task automatic model_reset(input int i);
        m_cyc[i] = 0;
        for (int c = 0; c < 2; c++) begin
            m_run[i][c]  = 0;
            m_s1[i][c]   = 1'b0;
            m_s2[i][c]   = 1'b0;
            m_d[i][c]    = 1'b0;
            m_rise[i][c] = 1'b0;
            m_fall[i][c] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit ra, input bit rb);
        bit raw [2];
        bit tk;
        raw[0] = ra;
        raw[1] = rb;
        tk = (m_cyc[i] % td_v[i]) == (td_v[i] - 1);
        m_cyc[i]++;
        for (int c = 0; c < 2; c++) begin
            m_rise[i][c] = 1'b0;
            m_fall[i][c] = 1'b0;
            if (tk) begin
                if (m_s2[i][c] != m_d[i][c]) begin
                    m_run[i][c]++;
                    if (m_run[i][c] == sc_v[i] + 1) begin
                        m_d[i][c]   = !m_d[i][c];
                        m_rise[i][c] = m_d[i][c];
                        m_fall[i][c] = !m_d[i][c];
                        m_run[i][c] = 0;
                    end
                end else begin
                    m_run[i][c] = 0;
                end
            end
            m_s2[i][c] = m_s1[i][c];
            m_s1[i][c] = raw[c];
        end
    endtask

    function automatic logic [5:0] obs(input int i);
        if (i == 0) return {a0, b0, ar0, br0, af0, bf0};
        return {a1, b1, ar1, br1, af1, bf1};
    endfunction

    function automatic logic [5:0] expv(input int i);
        return {m_d[i][0], m_d[i][1], m_rise[i][0], m_rise[i][1], m_fall[i][0], m_fall[i][1]};
    endfunction

    // ---------------- observation trackers ----------------
    int k;
    int first_a0, first_ar0, first_br0, first_af0, first_bf0, first_ar1;
    int n_ar0, n_br0, n_af0, n_bf0;
    int ever_a0;
    int run_ar1, max_ar1;

    task automatic clear_trk();
        k = 0;
        first_a0 = -1; first_ar0 = -1; first_br0 = -1;
        first_af0 = -1; first_bf0 = -1; first_ar1 = -1;
        n_ar0 = 0; n_br0 = 0; n_af0 = 0; n_bf0 = 0;
        ever_a0 = 0; run_ar1 = 0; max_ar1 = 0;
    endtask

    // One clock: model follows the edge, DUTs are compared 1 ns later.
    task automatic cyc();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_step(i, a_raw, b_raw);
        end
        #1;
        check("dut0_outs", obs(0), expv(0));
        check("dut1_outs", obs(1), expv(1));
        k++;
        if (a0) begin ever_a0 = 1; if (first_a0 < 0) first_a0 = k; end
        if (ar0) begin n_ar0++; if (first_ar0 < 0) first_ar0 = k; end
        if (br0) begin n_br0++; if (first_br0 < 0) first_br0 = k; end
        if (af0) begin n_af0++; if (first_af0 < 0) first_af0 = k; end
        if (bf0) begin n_bf0++; if (first_bf0 < 0) first_bf0 = k; end
        if (ar1) begin
            run_ar1++;
            if (run_ar1 > max_ar1) max_ar1 = run_ar1;
            if (first_ar1 < 0) first_ar1 = k;
        end else begin
            run_ar1 = 0;
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic reset_pulse(input int ncyc);
        #2;
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check("rst_async_dut0", obs(0), 6'b0);
        check("rst_async_dut1", obs(1), 6'b0);
        repeat (ncyc) cyc();
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        model_reset(0);
        model_reset(1);
        clear_trk();

        repeat (3) cyc();
        check("reset_state0", obs(0), 6'b0);
        check("reset_state1", obs(1), 6'b0);
        rst = 1'b0;
        repeat (20) cyc();

        // Reset mid-check with both raw inputs high, then recovery.
        a_raw = 1'b1; b_raw = 1'b1;
        repeat (5) cyc();
        reset_pulse(2);
        clear_trk();
        repeat (25) cyc();
        check("rst_rel_a_lat", first_a0, 13);
        check("rst_rel_arise_lat", first_ar0, 13);
        check("rst_rel_brise_lat", first_br0, 13);
        check("rst_rel_arise_cnt", n_ar0, 1);
        check("rst_rel_brise_cnt", n_br0, 1);
        check("presc_rise_lat", first_ar1, 12);
        check("presc_rise_width", max_ar1, 1);

        // Simultaneous fall on both channels.
        a_raw = 1'b0; b_raw = 1'b0;
        clear_trk();
        repeat (25) cyc();
        check("fall_a_lat", first_af0, 13);
        check("fall_b_lat", first_bf0, 13);
        check("fall_a_cnt", n_af0, 1);
        check("fall_b_cnt", n_bf0, 1);
        check("fall_levels", {a0, b0}, 2'b00);

        // Clean rise on A only.
        a_raw = 1'b1;
        clear_trk();
        repeat (25) cyc();
        check("rise_a_lat", first_ar0, 13);
        check("rise_a_cnt", n_ar0, 1);
        check("rise_b_quiet", n_br0 + n_bf0, 0);
        a_raw = 1'b0;
        repeat (25) cyc();

        // Bounce shorter than the acceptance window.
        clear_trk();
        for (int t = 0; t < 40; t++) begin
            a_raw = ((t / 3) % 2) == 0;
            cyc();
        end
        a_raw = 1'b0;
        repeat (20) cyc();
        check("bounce_no_rise", n_ar0, 0);
        check("bounce_no_fall", n_af0, 0);
        check("bounce_level", ever_a0, 0);

        // Marginal widths: 10 clks rejected, 11 clks accepted.
        clear_trk();
        a_raw = 1'b1;
        repeat (10) cyc();
        a_raw = 1'b0;
        repeat (25) cyc();
        check("marg10_no_rise", n_ar0, 0);
        check("marg10_level", ever_a0, 0);

        clear_trk();
        a_raw = 1'b1;
        repeat (11) cyc();
        a_raw = 1'b0;
        repeat (30) cyc();
        check("marg11_rise_cnt", n_ar0, 1);
        check("marg11_rise_lat", first_ar0, 13);
        check("marg11_fall_cnt", n_af0, 1);

        // Randomised holds with occasional asynchronous resets.
        for (int r = 0; r < 300; r++) begin
            a_raw = 1'($urandom_range(0, 1));
            b_raw = 1'($urandom_range(0, 1));
            hold  = $urandom_range(1, 16);
            repeat (hold) cyc();
            if ($urandom_range(0, 39) == 0) reset_pulse(int'($urandom_range(1, 3)));
        end
        repeat (40) cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
